// File: rtl/wt_dcache_repl_evq.sv
// wt_dcache_repl_evq: round-robin hit-event arbiter and FIFO feeding the PLRU updater; miss path passes through.
// Define WT_DCACHE_REPL_COALESCE_EN to merge a granted hit that repeats the newest queued (idx, way).
module wt_dcache_repl_evq #(
   parameter int unsigned NUM_PORTS  = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned IDX_WIDTH  = 8,
   parameter int unsigned WAY_WIDTH  = 2,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           flush_i,
   input  logic [NUM_PORTS-1:0]           hit_valid_i,
   input  logic [NUM_PORTS*IDX_WIDTH-1:0] hit_idx_i,
   input  logic [NUM_PORTS*WAY_WIDTH-1:0] hit_way_i,
   input  logic                           miss_valid_i,
   input  logic [IDX_WIDTH-1:0]           miss_idx_i,
   output logic                           plru_hit_o,
   output logic [IDX_WIDTH-1:0]           plru_hit_idx_o,
   output logic [WAY_WIDTH-1:0]           plru_hit_way_o,
   output logic                           plru_miss_o,
   output logic [IDX_WIDTH-1:0]           plru_miss_idx_o,
   output logic                           full_o,
   output logic [CNT_WIDTH-1:0]           drop_cnt_o
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned RW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned EW = IDX_WIDTH + WAY_WIDTH;

   logic [EW-1:0]        mem_q [FIFO_DEPTH];
   logic [PW-1:0]        rd_q, wr_q;
   logic [PW:0]          cnt_q;
   logic [RW-1:0]        rr_q, gnt_p;
   logic [CNT_WIDTH-1:0] drop_q;
   logic [NUM_PORTS-1:0] rot;
   logic [EW-1:0]        gnt_ev, head;
   logic [CNT_WIDTH:0]   sum;
   logic                 gnt, empty, pop, push, coal, full_drop;
   int                   c, n;

   // rotate so that bit 0 is the port at rr_q, then take the first set bit
   always_comb begin
      rot   = NUM_PORTS'({hit_valid_i, hit_valid_i} >> rr_q);
      gnt   = 1'b0;
      gnt_p = '0;
      c     = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!gnt && rot[k]) begin
            gnt   = 1'b1;
            c     = int'(rr_q) + k;
            gnt_p = RW'(c >= int'(NUM_PORTS) ? c - int'(NUM_PORTS) : c);
         end
      end
   end

   assign gnt_ev = {hit_idx_i[gnt_p*IDX_WIDTH +: IDX_WIDTH], hit_way_i[gnt_p*WAY_WIDTH +: WAY_WIDTH]};
   assign head   = mem_q[rd_q];
   assign empty  = cnt_q == '0;
   assign full_o = cnt_q == (PW+1)'(FIFO_DEPTH);

   // a head matching a concurrent miss waits one cycle so the hit lands after the miss
   assign plru_hit_o      = !empty && !(miss_valid_i && miss_idx_i == head[EW-1 -: IDX_WIDTH]);
   assign plru_hit_idx_o  = empty ? '0 : head[EW-1 -: IDX_WIDTH];
   assign plru_hit_way_o  = empty ? '0 : head[WAY_WIDTH-1:0];
   assign plru_miss_o     = miss_valid_i;
   assign plru_miss_idx_o = miss_idx_i;
   assign drop_cnt_o      = drop_q;
   assign pop             = plru_hit_o;

`ifdef WT_DCACHE_REPL_COALESCE_EN
   assign coal = gnt && !empty && mem_q[wr_q - PW'(1)] == gnt_ev && !(cnt_q == (PW+1)'(1) && pop);
`else
   assign coal = 1'b0;
`endif

   assign push      = gnt && !coal && (!full_o || pop) && !flush_i;
   assign full_drop = gnt && !coal && full_o && !pop;

   always_comb begin
      n   = $countones(hit_valid_i) - int'(gnt) + int'(full_drop);
      sum = {1'b0, drop_q} + (CNT_WIDTH+1)'(n);
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= gnt_ev;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         rr_q   <= '0;
         drop_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         rr_q  <= '0;
      end else begin
         if (pop) rd_q <= rd_q + PW'(1);
         if (push) wr_q <= wr_q + PW'(1);
         cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
         if (gnt) rr_q <= gnt_p == RW'(NUM_PORTS - 1) ? '0 : gnt_p + RW'(1);
         drop_q <= sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
      end
   end
endmodule

// File: tb/tb_wt_dcache_repl_evq.sv
// tb_wt_dcache_repl_evq: directed vector table, hand sequences and random traffic against a queue-based model.
module tb_wt_dcache_repl_evq;
   localparam int NP = 3, DEPTH = 4;

   logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
   logic [2:0]  hit_valid_i = '0;
   logic [23:0] hit_idx_i = '0;
   logic [5:0]  hit_way_i = '0;
   logic        miss_valid_i = 1'b0;
   logic [7:0]  miss_idx_i = '0;
   logic        plru_hit_o, plru_miss_o, full_o;
   logic [7:0]  plru_hit_idx_o, plru_miss_idx_o;
   logic [1:0]  plru_hit_way_o;
   logic [15:0] drop_cnt_o;

   wt_dcache_repl_evq dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .hit_valid_i(hit_valid_i), .hit_idx_i(hit_idx_i), .hit_way_i(hit_way_i),
      .miss_valid_i(miss_valid_i), .miss_idx_i(miss_idx_i),
      .plru_hit_o(plru_hit_o), .plru_hit_idx_o(plru_hit_idx_o), .plru_hit_way_o(plru_hit_way_o),
      .plru_miss_o(plru_miss_o), .plru_miss_idx_o(plru_miss_idx_o),
      .full_o(full_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {logic [7:0] idx; logic [1:0] way;} ev_t;
   ev_t q[$];
   int  rr = 0, drops = 0, checks = 0, errors = 0;

   typedef struct {
      logic [2:0] hv; logic [23:0] hi; logic [5:0] hw; logic mv; logic [7:0] mi; logic fl;
      logic e_hit; logic [7:0] e_idx; logic [1:0] e_way; logic e_full; int e_drop;
   } vec_t;
   vec_t tbl[15];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_hit();
      return q.size() > 0 && !(miss_valid_i && miss_idx_i == q[0].idx);
   endfunction

   task automatic model_check();
      chk("hit", int'(plru_hit_o), int'(model_hit()));
      if (q.size() > 0) begin
         chk("hit_idx", int'(plru_hit_idx_o), int'(q[0].idx));
         chk("hit_way", int'(plru_hit_way_o), int'(q[0].way));
      end
      chk("miss", int'(plru_miss_o), int'(miss_valid_i));
      chk("miss_idx", int'(plru_miss_idx_o), int'(miss_idx_i));
      chk("full", int'(full_o), int'(q.size() == DEPTH));
      chk("drop", int'(drop_cnt_o), drops);
   endtask

   task automatic model_step();
      bit hit = model_hit();
      int g = -1;
      ev_t e;
      if (flush_i) begin
         q.delete();
         rr = 0;
         return;
      end
      for (int k = 0; k < NP; k++)
         if (g < 0 && hit_valid_i[(rr + k) % NP]) g = (rr + k) % NP;
      if (hit) void'(q.pop_front());
      if (g >= 0) begin
         drops += $countones(hit_valid_i) - 1;
         rr = (g + 1) % NP;
         e.idx = hit_idx_i[g*8 +: 8];
         e.way = hit_way_i[g*2 +: 2];
`ifdef WT_DCACHE_REPL_COALESCE_EN
         if (q.size() > 0 && q[$] == e) e.idx = e.idx;
         else
`endif
         if (q.size() < DEPTH) q.push_back(e);
         else drops++;
      end
      if (drops > 65535) drops = 65535;
   endtask

   task automatic drive(input logic [2:0] hv, input logic [23:0] hi, input logic [5:0] hw,
                        input logic mv, input logic [7:0] mi, input logic fl);
      hit_valid_i = hv; hit_idx_i = hi; hit_way_i = hw;
      miss_valid_i = mv; miss_idx_i = mi; flush_i = fl;
      #3;
      model_check();
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         drive(3'b000, 24'h0, 6'h0, 1'b0, 8'h0, 1'b0);
         tick();
      end
   endtask

   initial begin
      tbl[0]  = '{3'b010, 24'h001200, 6'b001000, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 0};
      tbl[1]  = '{3'b000, 24'h000000, 6'b000000, 0, 8'h00, 0, 1, 8'h12, 2'd2, 0, 0};
      tbl[2]  = '{3'b000, 24'h000000, 6'b000000, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 0};
      tbl[3]  = '{3'b000, 24'h000000, 6'b000000, 0, 8'h00, 1, 0, 8'h00, 2'd0, 0, 0};
      tbl[4]  = '{3'b111, 24'h323130, 6'b100100, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 0};
      tbl[5]  = '{3'b111, 24'h323130, 6'b100100, 0, 8'h00, 0, 1, 8'h30, 2'd0, 0, 2};
      tbl[6]  = '{3'b111, 24'h323130, 6'b100100, 0, 8'h00, 0, 1, 8'h31, 2'd1, 0, 4};
      tbl[7]  = '{3'b000, 24'h000000, 6'b000000, 0, 8'h00, 0, 1, 8'h32, 2'd2, 0, 6};
      tbl[8]  = '{3'b000, 24'h000000, 6'b000000, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 6};
      tbl[9]  = '{3'b001, 24'h000020, 6'b000001, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 6};
      tbl[10] = '{3'b000, 24'h000000, 6'b000000, 1, 8'h20, 0, 0, 8'h20, 2'd1, 0, 6};
      tbl[11] = '{3'b000, 24'h000000, 6'b000000, 0, 8'h00, 0, 1, 8'h20, 2'd1, 0, 6};
      tbl[12] = '{3'b010, 24'h002000, 6'b001100, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 6};
      tbl[13] = '{3'b000, 24'h000000, 6'b000000, 1, 8'h21, 0, 1, 8'h20, 2'd3, 0, 6};
      tbl[14] = '{3'b000, 24'h000000, 6'b000000, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 6};

      #3;
      chk("rst_hit", int'(plru_hit_o), 0);
      chk("rst_idx", int'(plru_hit_idx_o), 0);
      chk("rst_way", int'(plru_hit_way_o), 0);
      chk("rst_full", int'(full_o), 0);
      chk("rst_drop", int'(drop_cnt_o), 0);
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_ni = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].hv, tbl[i].hi, tbl[i].hw, tbl[i].mv, tbl[i].mi, tbl[i].fl);
         chk($sformatf("tbl%0d_hit", i), int'(plru_hit_o), int'(tbl[i].e_hit));
         if (tbl[i].e_hit || tbl[i].mv) begin
            chk($sformatf("tbl%0d_idx", i), int'(plru_hit_idx_o), int'(tbl[i].e_idx));
            chk($sformatf("tbl%0d_way", i), int'(plru_hit_way_o), int'(tbl[i].e_way));
         end
         chk($sformatf("tbl%0d_full", i), int'(full_o), int'(tbl[i].e_full));
         chk($sformatf("tbl%0d_drop", i), int'(drop_cnt_o), tbl[i].e_drop);
         tick();
      end

      // full: head 0x40 held by a matching miss while port 2 keeps pushing
      for (int i = 0; i < 5; i++) begin
         drive(3'b100, {8'(8'h40 + i), 16'h0}, 6'h0, 1'b1, 8'h40, 1'b0);
         if (i == 4) chk("full_at_5th", int'(full_o), 1);
         tick();
      end
      drive(3'b100, 24'h450000, 6'h0, 1'b0, 8'h00, 1'b0);
      chk("full_drop", int'(drop_cnt_o), 7);
      chk("full_release_hit", int'(plru_hit_idx_o), 'h40);
      tick();
      drive(3'b000, 24'h0, 6'h0, 1'b0, 8'h00, 1'b0);
      chk("full_stays", int'(full_o), 1);
      chk("full_next_head", int'(plru_hit_idx_o), 'h41);
      tick();
      idle(5);

      // coalesce candidate: (0x05,1) twice behind a held head
      drive(3'b001, 24'h000005, 6'b000001, 1'b1, 8'h05, 1'b0); tick();
      drive(3'b001, 24'h000005, 6'b000001, 1'b1, 8'h05, 1'b0); tick();
      drive(3'b000, 24'h0, 6'h0, 1'b0, 8'h00, 1'b0);
      chk("coal_first", int'(plru_hit_o), 1);
      tick();
      drive(3'b000, 24'h0, 6'h0, 1'b0, 8'h00, 1'b0);
`ifdef WT_DCACHE_REPL_COALESCE_EN
      chk("coal_second", int'(plru_hit_o), 0);
`else
      chk("coal_second", int'(plru_hit_o), 1);
`endif
      tick();
      idle(2);

      // flush with three entries queued plus a new event
      for (int i = 0; i < 3; i++) begin
         drive(3'b111, 24'h626160, 6'b100100, 1'b1, 8'h61, 1'b0);
         tick();
      end
      drive(3'b111, 24'h727170, 6'b100100, 1'b1, 8'h61, 1'b1);
      tick();
      drive(3'b111, 24'h535251, 6'b100100, 1'b0, 8'h00, 1'b0);
      chk("flush_empty", int'(plru_hit_o), 0);
      chk("flush_full", int'(full_o), 0);
      tick();
      drive(3'b000, 24'h0, 6'h0, 1'b0, 8'h00, 1'b0);
      chk("flush_rr0", int'(plru_hit_idx_o), 'h51);
      tick();

      for (int i = 0; i < 600; i++) begin
         drive(3'($urandom), {8'($urandom_range(3)), 8'($urandom_range(3)), 8'($urandom_range(3))},
               6'($urandom), $urandom_range(9) < 3, 8'($urandom_range(3)), $urandom_range(39) == 0);
         tick();
         if (i == 300) begin
            hit_valid_i = '0; miss_valid_i = 1'b0; flush_i = 1'b0;
            #2 rst_ni = 1'b0;
            #1;
            chk("arst_hit", int'(plru_hit_o), 0);
            chk("arst_idx", int'(plru_hit_idx_o), 0);
            chk("arst_way", int'(plru_hit_way_o), 0);
            chk("arst_full", int'(full_o), 0);
            chk("arst_drop", int'(drop_cnt_o), 0);
            q.delete(); rr = 0; drops = 0;
            @(posedge clk_i); #1;
            rst_ni = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
